// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain controller for a bank of NUM_Q source FIFOs feeding one destination FIFO.
// Define FIFO_SCHED_STRICT_PRIO_EN for fixed priority (lowest non-empty index wins).
module fifo_rr_scheduler #(
    parameter int DATA_SIZE = 12,
    parameter int NUM_Q     = 4,
    parameter int TH_SIZE   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic [TH_SIZE-1:0]         th_full_cfg,
    input  logic [TH_SIZE-1:0]         th_empty_cfg,
    input  logic [NUM_Q-1:0]           fifo_empty,
    input  logic [NUM_Q-1:0]           fifo_error,
    input  logic [NUM_Q*DATA_SIZE-1:0] fifo_data_out,
    input  logic                       dest_pause,
    output logic [NUM_Q-1:0]           pop,
    output logic                       push,
    output logic [DATA_SIZE-1:0]       data_out,
    output logic [TH_SIZE-1:0]         th_almost_full,
    output logic [TH_SIZE-1:0]         th_almost_empty,
    output logic [2:0]                 state,
    output logic                       idle,
    output logic                       error_out
);
    localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [QW-1:0]        grant;
    logic                 have_grant;
    logic                 pop_en;
    logic                 any_err;
    logic                 all_empty;
    logic                 push_q;
    logic [QW-1:0]        gidx_q;
    logic [TH_SIZE-1:0]   th_full_q, th_empty_q;
    logic                 idle_q, error_q;
    logic [DATA_SIZE-1:0] word [NUM_Q];

    assign any_err   = |fifo_error;
    assign all_empty = &fifo_empty;

`ifdef FIFO_SCHED_STRICT_PRIO_EN
    always_comb begin
        grant      = '0;
        have_grant = 1'b0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (!fifo_empty[i]) begin
                have_grant = 1'b1;
                grant      = QW'(i);
            end
        end
    end
`else
    logic [QW-1:0] last_q;
    logic [QW-1:0] cand;
    int            rr_idx;

    // Search starts just past the last served queue so every non-empty queue waits at most K-1 grants.
    always_comb begin
        grant      = '0;
        have_grant = 1'b0;
        rr_idx     = 0;
        cand       = '0;
        for (int k = 1; k <= NUM_Q; k++) begin
            rr_idx = int'(last_q) + k;
            if (rr_idx >= NUM_Q) rr_idx = rr_idx - NUM_Q;
            cand = QW'(rr_idx);
            if (!have_grant && !fifo_empty[cand]) begin
                have_grant = 1'b1;
                grant      = cand;
            end
        end
    end
`endif

    assign pop_en = (state_q == S_ACTIVE) && have_grant && !dest_pause && !any_err;
    assign pop    = pop_en ? (NUM_Q'(1) << grant) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT:   if (any_err) state_d = S_ERROR;
                      else if (!init) state_d = S_IDLE;
            S_IDLE:   if (any_err) state_d = S_ERROR;
                      else if (!all_empty && !dest_pause) state_d = S_ACTIVE;
            S_ACTIVE: if (any_err) state_d = S_ERROR;
                      else if (all_empty) state_d = S_IDLE;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RESET;
            push_q     <= 1'b0;
            th_full_q  <= '0;
            th_empty_q <= '0;
            idle_q     <= 1'b0;
            error_q    <= 1'b0;
`ifndef FIFO_SCHED_STRICT_PRIO_EN
            last_q     <= QW'(NUM_Q - 1);
`endif
        end else begin
            state_q <= state_d;
            push_q  <= |pop;
            idle_q  <= (state_d == S_IDLE);
            error_q <= error_q | (state_d == S_ERROR);
            if (state_q == S_INIT) begin
                th_full_q  <= th_full_cfg;
                th_empty_q <= th_empty_cfg;
            end
`ifndef FIFO_SCHED_STRICT_PRIO_EN
            if (|pop) last_q <= grant;
`endif
        end
    end

    // Pure data path: the index only matters while push_q marks it valid.
    always_ff @(posedge clk) begin
        if (|pop) gidx_q <= grant;
    end

    always_comb begin
        for (int i = 0; i < NUM_Q; i++) word[i] = fifo_data_out[i*DATA_SIZE +: DATA_SIZE];
    end

    // Source FIFOs register their output on the pop edge, so the word lines up with push_q.
    assign data_out        = push_q ? word[gidx_q] : '0;
    assign push            = push_q;
    assign th_almost_full  = th_full_q;
    assign th_almost_empty = th_empty_q;
    assign state           = state_q;
    assign idle            = idle_q;
    assign error_out       = error_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Scoreboard bench for fifo_rr_scheduler: a behavioural source-FIFO bank feeds the DUT,
// expected pop/push streams are queued at load time and checked by a separate monitor.
module tb_fifo_rr_scheduler;
    localparam int NQ = 4;
    localparam int DW = 12;
    localparam int TW = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               init = 1'b1;
    logic [TW-1:0]      th_full_cfg = 3'd6;
    logic [TW-1:0]      th_empty_cfg = 3'd1;
    logic [NQ-1:0]      fifo_empty = 4'hF;
    logic [NQ-1:0]      fifo_error = 4'h0;
    logic [NQ*DW-1:0]   fifo_data_out;
    logic               dest_pause = 1'b0;
    logic [NQ-1:0]      pop;
    logic               push;
    logic [DW-1:0]      data_out;
    logic [TW-1:0]      th_almost_full;
    logic [TW-1:0]      th_almost_empty;
    logic [2:0]         state;
    logic               idle;
    logic               error_out;

    logic [DW-1:0]      srcq [NQ][$];
    logic [DW-1:0]      dreg [NQ] = '{12'h0, 12'h0, 12'h0, 12'h0};
    logic [DW-1:0]      mw;
    logic [NQ-1:0]      exp_pop [$];
    logic [DW-1:0]      exp_data [$];
    int                 n_vec = 0;
    int                 n_err = 0;

    fifo_rr_scheduler #(.DATA_SIZE(DW), .NUM_Q(NQ), .TH_SIZE(TW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .th_full_cfg(th_full_cfg), .th_empty_cfg(th_empty_cfg),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error), .fifo_data_out(fifo_data_out),
        .dest_pause(dest_pause), .pop(pop), .push(push), .data_out(data_out),
        .th_almost_full(th_almost_full), .th_almost_empty(th_almost_empty),
        .state(state), .idle(idle), .error_out(error_out)
    );

    always #5 clk = ~clk;

    // Source FIFO bank: registered data output, empty flag updated on the pop edge.
    always @(posedge clk) begin
        for (int i = 0; i < NQ; i++) begin
            if (pop[i] && srcq[i].size() > 0) begin
                mw = srcq[i].pop_front();
                dreg[i] <= mw;
            end
            fifo_empty[i] <= (srcq[i].size() == 0);
        end
    end

    always_comb begin
        fifo_data_out = '0;
        for (int i = 0; i < NQ; i++) fifo_data_out[i*DW +: DW] = dreg[i];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every pop and every push against the scoreboard queues.
    always @(negedge clk) begin
        if (pop !== 4'b0000) begin
            if (exp_pop.size() == 0) chk("pop_unexpected", 32'(pop), 32'h0);
            else chk("pop_order", 32'(pop), 32'(exp_pop.pop_front()));
        end
        if (push === 1'b1) begin
            if (exp_data.size() == 0) chk("push_unexpected", 32'(push), 32'h0);
            else chk("push_data", 32'(data_out), 32'(exp_data.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int q, input logic [DW-1:0] w);
        srcq[q].push_back(w);
    endtask

    task automatic ex(input int q, input logic [DW-1:0] w);
        logic [NQ-1:0] b;
        b = 4'b0001 << q;
        exp_pop.push_back(b);
        exp_data.push_back(w);
    endtask

    task automatic wait_state(input logic [2:0] s, input string nm);
        for (int k = 0; k < 40; k++) begin
            if (state == s) break;
            tick();
        end
        chk(nm, 32'(state), 32'(s));
    endtask

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 60; k++) begin
            if (state == 3'd2 && exp_pop.size() == 0 && exp_data.size() == 0) break;
            tick();
        end
        chk(nm, 32'(state), 32'd2);
        chk({nm, "_sb_empty"}, 32'(exp_pop.size() + exp_data.size()), 32'd0);
        chk({nm, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_th_full", 32'(th_almost_full), 32'd0);
        chk("rst_th_empty", 32'(th_almost_empty), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);
        chk("rst_err", 32'(error_out), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("init_state", 32'(state), 32'd1);
        tick();
        tick();
        init = 1'b0;
        tick();
        chk("idle_state", 32'(state), 32'd2);
        chk("idle_flag", 32'(idle), 32'd1);
        chk("th_full", 32'(th_almost_full), 32'd6);
        chk("th_empty", 32'(th_almost_empty), 32'd1);

        // Three queues, two words each.
        ld(0, 12'hA00); ld(0, 12'hA01); ld(1, 12'hB00); ld(1, 12'hB01); ld(3, 12'hD00); ld(3, 12'hD01);
`ifdef FIFO_SCHED_STRICT_PRIO_EN
        ex(0, 12'hA00); ex(0, 12'hA01); ex(1, 12'hB00); ex(1, 12'hB01); ex(3, 12'hD00); ex(3, 12'hD01);
`else
        ex(0, 12'hA00); ex(1, 12'hB00); ex(3, 12'hD00); ex(0, 12'hA01); ex(1, 12'hB01); ex(3, 12'hD01);
`endif
        wait_state(3'd3, "t2_active");
        wait_drain("t2_drain");

        // Same load, destination paused after three pops for three cycles.
        ld(0, 12'hA10); ld(0, 12'hA11); ld(1, 12'hB10); ld(1, 12'hB11); ld(3, 12'hD10); ld(3, 12'hD11);
`ifdef FIFO_SCHED_STRICT_PRIO_EN
        ex(0, 12'hA10); ex(0, 12'hA11); ex(1, 12'hB10); ex(1, 12'hB11); ex(3, 12'hD10); ex(3, 12'hD11);
`else
        ex(0, 12'hA10); ex(1, 12'hB10); ex(3, 12'hD10); ex(0, 12'hA11); ex(1, 12'hB11); ex(3, 12'hD11);
`endif
        wait_state(3'd3, "t3_active");
        tick(); tick(); tick();
        dest_pause = 1'b1;
        #1;
        chk("t3_push_inflight", 32'(push), 32'd1);
        chk("t3_pause_pop", 32'(pop), 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("t3_pause_pop", 32'(pop), 32'd0);
            chk("t3_pause_push", 32'(push), 32'd0);
            chk("t3_pause_state", 32'(state), 32'd3);
        end
        tick();
        dest_pause = 1'b0;
        wait_drain("t3_drain");

        // Single word in q2 only.
        ld(2, 12'hC00);
        ex(2, 12'hC00);
        wait_state(3'd3, "t4_active");
        wait_drain("t4_drain");

        // q0 and q2 with three words each.
        ld(0, 12'hF00); ld(0, 12'hF01); ld(0, 12'hF02); ld(2, 12'hF20); ld(2, 12'hF21); ld(2, 12'hF22);
`ifdef FIFO_SCHED_STRICT_PRIO_EN
        ex(0, 12'hF00); ex(0, 12'hF01); ex(0, 12'hF02); ex(2, 12'hF20); ex(2, 12'hF21); ex(2, 12'hF22);
`else
        ex(0, 12'hF00); ex(2, 12'hF20); ex(0, 12'hF01); ex(2, 12'hF21); ex(0, 12'hF02); ex(2, 12'hF22);
`endif
        wait_state(3'd3, "t6_active");
        wait_drain("t6_drain");

        // Error mid-drain: only the first pop completes.
        ld(0, 12'hE00); ld(0, 12'hE01); ld(1, 12'hE10); ld(1, 12'hE11);
        ex(0, 12'hE00);
        wait_state(3'd3, "t5_active");
        tick();
        fifo_error = 4'b0010;
        #1;
        chk("t5_pop_gated", 32'(pop), 32'd0);
        tick();
        chk("t5_state", 32'(state), 32'd4);
        chk("t5_err", 32'(error_out), 32'd1);
        chk("t5_pop", 32'(pop), 32'd0);
        chk("t5_push", 32'(push), 32'd0);
        fifo_error = 4'b0000;
        tick(); tick();
        chk("t5_state_hold", 32'(state), 32'd4);
        chk("t5_err_sticky", 32'(error_out), 32'd1);
        chk("t5_pop_hold", 32'(pop), 32'd0);
        chk("t5_inflight_done", 32'(exp_data.size()), 32'd0);
        reset = 1'b1;
        #1;
        chk("t5_rst_state", 32'(state), 32'd0);
        chk("t5_rst_err", 32'(error_out), 32'd0);
        chk("t5_rst_th_full", 32'(th_almost_full), 32'd0);
        chk("t5_rst_th_empty", 32'(th_almost_empty), 32'd0);
        chk("t5_rst_idle", 32'(idle), 32'd0);
        chk("t5_rst_push", 32'(push), 32'd0);
        for (int i = 0; i < NQ; i++) srcq[i].delete();
        tick(); tick();
        reset = 1'b0;
        init = 1'b1;
        tick();
        chk("t5_reinit_state", 32'(state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
